// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for the skid pipeline stage
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 3;
    localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one pipeline entry (valid bit + payload) with load and clear; clear wins and zeroes ctrl
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int CTRL_WIDTH = CTRL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] d_data,
    input  logic [CTRL_WIDTH-1:0] d_ctrl,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CTRL_WIDTH-1:0] ctrl
);

    // entry register: invalidation zeroes ctrl, data is left stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry elastic stage (main + skid) with registered in_ready; PIPE_SKID_PERF_EN adds stall/bubble counters
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int CTRL_WIDTH = CTRL_W_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

    state_t state, state_nx;
    logic accept, release_;
    logic m_load, m_clear, s_load, s_clear;
    logic s_valid;
    logic [DATA_WIDTH-1:0] s_data, m_d_data;
    logic [CTRL_WIDTH-1:0] s_ctrl, m_d_ctrl;

    assign accept   = in_valid && in_ready;
    assign release_ = out_valid && out_ready;
    // main refills from the skid whenever the skid holds the older entry
    assign m_d_data = s_valid ? s_data : in_data;
    assign m_d_ctrl = s_valid ? s_ctrl : in_ctrl;

    // state register and registered in_ready (no path from out_ready)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != TWO);
        end
    end

    // next state and entry load/clear strobes; flush overrides everything
    always_comb begin
        state_nx = state;
        m_load   = 1'b0;
        m_clear  = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
            m_clear  = 1'b1;
            s_clear  = 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx = ONE;
                    m_load   = 1'b1;
                end
                ONE: if (accept && release_) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    state_nx = TWO;
                    s_load   = 1'b1;
                end else if (release_) begin
                    state_nx = EMPTY;
                    m_clear  = 1'b1;
                end
                TWO: if (release_) begin
                    state_nx = ONE;
                    m_load   = 1'b1;
                    s_clear  = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    pipe_entry_reg #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (m_load),
        .clear  (m_clear),
        .d_data (m_d_data),
        .d_ctrl (m_d_ctrl),
        .valid  (out_valid),
        .data   (out_data),
        .ctrl   (out_ctrl)
    );

    pipe_entry_reg #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (s_load),
        .clear  (s_clear),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (s_valid),
        .data   (s_data),
        .ctrl   (s_ctrl)
    );

`ifdef PIPE_SKID_PERF_EN
    // saturating stall/bubble counters; only reset clears them, flush does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && !flush && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif

endmodule
